// File: rtl/epp_host.sv
// EPP host/initiator: turns single-byte address/data read/write commands into
// nWrite/strobe/nWait handshakes with a per-wait-state timeout.
module epp_host #(
    parameter int SETUP_CYC = 4,
    parameter int HOLD_CYC  = 2,
    parameter int TIMEOUT   = 1000,
    parameter int TW        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic [7:0] pport_data_out,
    output logic       pport_data_oe,
    input  logic [7:0] pport_data_in,
    output logic       nWrite,
    output logic       nDataStr,
    output logic       nAddrStr,
    input  logic       nWait,
    output logic       epp_nReset
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE,
        HOLD
    } state_t;

    localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);

    state_t        state, state_n;
    logic [TW-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]    op, op_n;
    logic          to_flag, to_flag_n;
    logic          wait_meta, wait_s;

    logic       nwrite_n, ndstr_n, nastr_n, oe_n, rsp_valid_n, rsp_timeout_n;
    logic [7:0] dout_n, rsp_data_n;

    // Ready depends on state only; reset is folded in so nothing is accepted
    // while the block is being held in reset.
    assign cmd_ready = (state == IDLE) && !reset;

    // Saturating increment: the counter parks at TIMEOUT instead of wrapping.
    assign cnt_inc = (cnt >= TO_MAX) ? cnt : cnt + TW'(1);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt_inc;
        op_n          = op;
        to_flag_n     = to_flag;
        nwrite_n      = nWrite;
        ndstr_n       = nDataStr;
        nastr_n       = nAddrStr;
        oe_n          = pport_data_oe;
        dout_n        = pport_data_out;
        rsp_valid_n   = 1'b0;
        rsp_data_n    = rsp_data;
        rsp_timeout_n = rsp_timeout;

        case (state)
            IDLE: begin
                cnt_n = '0;
                // A low wait_s means the peripheral still holds the bus; defer.
                if (cmd_valid && wait_s) begin
                    op_n          = cmd_op;
                    to_flag_n     = 1'b0;
                    nwrite_n      = cmd_op[1];
                    oe_n          = !cmd_op[1];
                    dout_n        = cmd_op[1] ? 8'h00 : cmd_data;
                    rsp_data_n    = 8'h00;
                    rsp_timeout_n = 1'b0;
                    state_n       = SETUP;
                end
            end

            SETUP: begin
                if (cnt >= SETUP_LAST) begin
                    if (op[0]) nastr_n = 1'b0;
                    else       ndstr_n = 1'b0;
                    cnt_n   = '0;
                    state_n = STROBE;
                end
            end

            STROBE: begin
                if (!wait_s) begin
                    if (op[1]) rsp_data_n = pport_data_in;
                    ndstr_n = 1'b1;
                    nastr_n = 1'b1;
                    cnt_n   = '0;
                    state_n = RELEASE;
                end else if (cnt >= TO_LAST) begin
                    ndstr_n   = 1'b1;
                    nastr_n   = 1'b1;
                    to_flag_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = HOLD;
                end
            end

            RELEASE: begin
                if (wait_s) begin
                    cnt_n   = '0;
                    state_n = HOLD;
                end else if (cnt >= TO_LAST) begin
                    to_flag_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = HOLD;
                end
            end

            HOLD: begin
                if (cnt >= HOLD_LAST) begin
                    nwrite_n      = 1'b1;
                    oe_n          = 1'b0;
                    dout_n        = 8'h00;
                    rsp_valid_n   = 1'b1;
                    rsp_timeout_n = to_flag;
                    if (to_flag) rsp_data_n = 8'h00;
                    cnt_n         = '0;
                    state_n       = IDLE;
                end
            end

            default: begin
                state_n  = IDLE;
                cnt_n    = '0;
                nwrite_n = 1'b1;
                ndstr_n  = 1'b1;
                nastr_n  = 1'b1;
                oe_n     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        epp_nReset <= !reset;
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            op             <= 2'b00;
            to_flag        <= 1'b0;
            wait_meta      <= 1'b1;
            wait_s         <= 1'b1;
            nWrite         <= 1'b1;
            nDataStr       <= 1'b1;
            nAddrStr       <= 1'b1;
            pport_data_oe  <= 1'b0;
            pport_data_out <= 8'h00;
            rsp_valid      <= 1'b0;
            rsp_data       <= 8'h00;
            rsp_timeout    <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            op             <= op_n;
            to_flag        <= to_flag_n;
            wait_meta      <= nWait;
            wait_s         <= wait_meta;
            nWrite         <= nwrite_n;
            nDataStr       <= ndstr_n;
            nAddrStr       <= nastr_n;
            pport_data_oe  <= oe_n;
            pport_data_out <= dout_n;
            rsp_valid      <= rsp_valid_n;
            rsp_data       <= rsp_data_n;
            rsp_timeout    <= rsp_timeout_n;
        end
    end

endmodule

// File: tb/tb_epp_host.sv
// Bench for epp_host: a behavioural EPP slave (pluto_servo-like register map)
// answers the host; responses are checked against an expected queue.
module tb_epp_host;

    localparam int SETUP_CYC = 4;
    localparam int HOLD_CYC  = 2;
    localparam int TIMEOUT   = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic [7:0] pport_data_out;
    logic       pport_data_oe;
    logic [7:0] pport_data_in;
    logic       nWrite, nDataStr, nAddrStr, nWait, epp_nReset;

    // Slave model state (responder process writes, tests only read).
    logic        resp_nwait = 1'b1;
    logic [7:0]  resp_byte = 8'h00;
    logic [7:0]  slave_addr = 8'h00;
    logic [15:0] pwm0 = 16'h0000;
    // Test knobs (main process writes, responder only reads).
    logic        force_busy = 1'b0;
    logic        slave_mute = 1'b0;
    int          ack_dly = 3;
    int          rel_dly = 1;
    logic [31:0] quad0 = 32'h0;
    logic [7:0]  misc_byte = 8'hA5;

    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int viol = 0;
    int rsp_count = 0;

    always #5 clk = ~clk;

    assign nWait = resp_nwait & ~force_busy;
    assign pport_data_in = resp_nwait ? 8'h00 : resp_byte;

    epp_host #(.SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT), .TW(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .pport_data_out(pport_data_out), .pport_data_oe(pport_data_oe),
        .pport_data_in(pport_data_in),
        .nWrite(nWrite), .nDataStr(nDataStr), .nAddrStr(nAddrStr),
        .nWait(nWait), .epp_nReset(epp_nReset)
    );

    function automatic logic [7:0] read_model(input logic [7:0] a);
        return (a < 8'd4) ? quad0[8*a[1:0] +: 8] : misc_byte;
    endfunction

    // EPP slave: ack ack_dly cycles after seeing a strobe, release after rel_dly.
    initial begin : responder
        logic is_addr, is_write;
        logic [7:0] wdata;
        forever begin
            @(posedge clk); #2;
            if (!slave_mute && (!nAddrStr || !nDataStr)) begin
                is_addr  = !nAddrStr;
                is_write = !nWrite;
                wdata    = pport_data_out;
                repeat (ack_dly) begin @(posedge clk); #2; end
                if (is_write) begin
                    resp_byte = 8'h00;
                    if (is_addr) slave_addr = wdata;
                    else begin
                        if (slave_addr == 8'd8) pwm0[7:0] = wdata;
                        if (slave_addr == 8'd9) pwm0[15:8] = wdata;
                        slave_addr = slave_addr + 8'd1;
                    end
                end else begin
                    if (is_addr) resp_byte = slave_addr;
                    else begin
                        resp_byte  = read_model(slave_addr);
                        slave_addr = slave_addr + 8'd1;
                    end
                end
                resp_nwait = 1'b0;
                for (int k = 0; k < 3000 && (!nAddrStr || !nDataStr); k++) begin
                    @(posedge clk); #2;
                end
                repeat (rel_dly) begin @(posedge clk); #2; end
                resp_nwait = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!nAddrStr && !nDataStr) viol++;
        if (pport_data_oe && nWrite) viol++;
        if (rsp_valid === 1'b1) rsp_count++;
    end

    // Driver: hold cmd_valid until the host leaves IDLE; waited = negedges taken.
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] data, output int waited);
        waited = -1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b0) begin
                waited = i;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    // Returns {timeout, data} of the next response, or X if none arrives.
    task automatic wait_rsp(output logic [8:0] got);
        got = 'x;
        for (int i = 0; i < 3000; i++) begin
            if (rsp_valid === 1'b1) begin
                got = {rsp_timeout, rsp_data};
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({nWrite, nDataStr, nAddrStr, pport_data_oe, pport_data_out, rsp_valid, rsp_data,
             rsp_timeout, cmd_ready, epp_nReset} !== {3'b111, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000}) begin
            n_errors++;
            $display("FAIL reset_values: got nW=%b nDS=%b nAS=%b oe=%b dout=%h rv=%b rd=%h rt=%b rdy=%b nrst=%b",
                     nWrite, nDataStr, nAddrStr, pport_data_oe, pport_data_out, rsp_valid, rsp_data,
                     rsp_timeout, cmd_ready, epp_nReset);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, epp_nReset} !== 2'b11) begin
            n_errors++;
            $display("FAIL after_reset: got ready=%b nReset=%b, expected 1 1", cmd_ready, epp_nReset);
        end
    endtask

    task automatic test_addr_write();
        int w, setup_n, falls, strobe_n, hold_n, bad_bus, ds_low;
        logic prev_as, seen_ack, done;
        logic [8:0] got, exp;
        ack_dly = 3; rel_dly = 1;
        setup_n = 0; falls = 0; strobe_n = 0; hold_n = 0; bad_bus = 0; ds_low = 0;
        prev_as = 1'b1; seen_ack = 1'b0; done = 1'b0; got = 'x;
        exp_q.push_back({1'b0, 8'h00});
        send_cmd(2'b01, 8'h09, w);
        for (int i = 0; i < 3000 && !done; i++) begin
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
                got = {rsp_timeout, rsp_data};
            end else begin
                if (nWrite !== 1'b0 || pport_data_out !== 8'h09 || pport_data_oe !== 1'b1) bad_bus++;
                if (!nAddrStr) strobe_n++;
                if (prev_as && !nAddrStr) falls++;
                if (!nDataStr) ds_low++;
                if (nAddrStr && falls == 0) setup_n++;
                if (nWait && seen_ack && nAddrStr) hold_n++;
                if (!nWait) seen_ack = 1'b1;
                prev_as = nAddrStr;
                @(negedge clk);
            end
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL aw_rsp: got %h expected %h", got, exp); end
        n_checks++;
        if (setup_n != SETUP_CYC) begin n_errors++; $display("FAIL aw_setup: got %0d expected %0d", setup_n, SETUP_CYC); end
        n_checks++;
        if (falls != 1) begin n_errors++; $display("FAIL aw_strobe_count: got %0d expected 1", falls); end
        // Strobe window: 3-cycle responder delay + 2 sync stages + 1 detect cycle.
        n_checks++;
        if (strobe_n != 6) begin n_errors++; $display("FAIL aw_strobe_len: got %0d expected 6", strobe_n); end
        // After nWait rises: 2 sync stages + 1 cycle for RELEASE to see it + HOLD_CYC.
        n_checks++;
        if (hold_n != HOLD_CYC + 3) begin n_errors++; $display("FAIL aw_hold: got %0d expected %0d", hold_n, HOLD_CYC + 3); end
        n_checks++;
        if (bad_bus != 0) begin n_errors++; $display("FAIL aw_bus_stable: got %0d unstable cycles expected 0", bad_bus); end
        n_checks++;
        if (ds_low != 0) begin n_errors++; $display("FAIL aw_wrong_strobe: got %0d nDataStr cycles expected 0", ds_low); end
        n_checks++;
        if (slave_addr !== 8'h09) begin n_errors++; $display("FAIL aw_slave_addr: got %h expected 09", slave_addr); end
    endtask

    task automatic test_data_read();
        int w, bad;
        logic done;
        logic [8:0] got, exp;
        ack_dly = 2; rel_dly = 2; bad = 0; done = 1'b0; got = 'x;
        exp_q.push_back({1'b0, misc_byte});
        send_cmd(2'b10, 8'hFF, w);
        for (int i = 0; i < 3000 && !done; i++) begin
            if (pport_data_oe !== 1'b0 || nWrite !== 1'b1) bad++;
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
                got = {rsp_timeout, rsp_data};
            end else @(negedge clk);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL rd_rsp: got %h expected %h", got, exp); end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL rd_bus_dir: got %0d driven cycles expected 0", bad); end
    endtask

    task automatic test_timeout();
        int w, low_n;
        logic done;
        logic [8:0] got, exp;
        slave_mute = 1'b1; low_n = 0; done = 1'b0; got = 'x;
        exp_q.push_back({1'b1, 8'h00});
        send_cmd(2'b10, 8'h00, w);
        for (int i = 0; i < 3000 && !done; i++) begin
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
                got = {rsp_timeout, rsp_data};
            end else begin
                if (!nDataStr) low_n++;
                @(negedge clk);
            end
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL to_rsp: got %h expected %h", got, exp); end
        n_checks++;
        if (low_n != TIMEOUT) begin n_errors++; $display("FAIL to_strobe_len: got %0d expected %0d", low_n, TIMEOUT); end
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL to_next_cycle: got ready=%b rsp_valid=%b expected 1 0", cmd_ready, rsp_valid);
        end
        slave_mute = 1'b0;
    endtask

    task automatic test_busy_idle();
        int w, bad;
        logic [8:0] got, exp;
        ack_dly = 1; rel_dly = 1; bad = 0;
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h5A;
        repeat (8) begin
            @(negedge clk);
            if (cmd_ready !== 1'b1 || nDataStr !== 1'b1 || nAddrStr !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL busy_no_accept: got %0d bad cycles expected 0", bad); end
        force_busy = 1'b0;
        exp_q.push_back({1'b0, 8'h00});
        send_cmd(2'b00, 8'h5A, w);
        wait_rsp(got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL busy_then_rsp: got %h expected %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [8];
        logic [7:0] dat [8];
        int w;
        logic [8:0] got, exp;
        quad0 = $urandom;
        ack_dly = $urandom_range(1, 4);
        rel_dly = $urandom_range(0, 3);
        ops = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
        dat = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h34, 8'h12};
        for (int i = 0; i < 8; i++) begin
            if (ops[i] == 2'b10) exp_q.push_back({1'b0, quad0[8*(i-1) +: 8]});
            else                 exp_q.push_back({1'b0, 8'h00});
            send_cmd(ops[i], dat[i], w);
            if (i > 0) begin
                n_checks++;
                if (w != 1) begin n_errors++; $display("FAIL b2b_accept[%0d]: got %0d cycles expected 1", i, w); end
            end
            wait_rsp(got);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL burst_rsp[%0d]: got %h expected %h", i, got, exp); end
        end
        n_checks++;
        if (pwm0 !== 16'h1234) begin n_errors++; $display("FAIL burst_pwm0: got %h expected 1234", pwm0); end
    endtask

    task automatic test_reset_in_strobe();
        int w, snap;
        logic [8:0] got, exp;
        ack_dly = 20; rel_dly = 1;
        send_cmd(2'b00, 8'h77, w);
        for (int i = 0; i < 100 && nDataStr !== 1'b0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        snap = rsp_count;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({nDataStr, nAddrStr, pport_data_oe, nWrite, rsp_valid, cmd_ready} !== 6'b110100) begin
            n_errors++;
            $display("FAIL mid_reset: got nDS=%b nAS=%b oe=%b nW=%b rv=%b rdy=%b expected 1 1 0 1 0 0",
                     nDataStr, nAddrStr, pport_data_oe, nWrite, rsp_valid, cmd_ready);
        end
        reset = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (rsp_count != snap) begin n_errors++; $display("FAIL mid_reset_no_rsp: got %0d responses expected 0", rsp_count - snap); end
        ack_dly = 2;
        exp_q.push_back({1'b0, 8'h00});
        send_cmd(2'b01, 8'h08, w);
        wait_rsp(got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL post_reset_aw: got %h expected %h", got, exp); end
        exp_q.push_back({1'b0, 8'h00});
        send_cmd(2'b00, 8'hCD, w);
        wait_rsp(got);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL post_reset_dw: got %h expected %h", got, exp); end
        n_checks++;
        if (pwm0 !== 16'h12CD) begin n_errors++; $display("FAIL post_reset_pwm0: got %h expected 12cd", pwm0); end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (viol != 0) begin n_errors++; $display("FAIL protocol: got %0d violations expected 0", viol); end
        n_checks++;
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_left: got %0d entries expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_addr_write();
        test_data_read();
        test_timeout();
        test_busy_idle();
        test_back_to_back();
        test_reset_in_strobe();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
